integrate_dump_detector: RTL

//  Receive-side symbol detector placed directly after the channel block. Consumes the 16-bit

---
 rtl/comm_pkg.sv | 21 ++
 rtl/decision_buffer.sv | 66 ++++++
 rtl/integrate_dump_detector.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// comm_pkg
//   Shared definitions for the transmit/channel/receive chain.
//   - DEF_SAMPLE_W, DEF_SPS, DEF_ERASE_TH : defaults shared with the
//     transmitter and channel benches
//   - sample_t    : one signed channel sample
//   - det_state_e : receive-side symbol detector states
package comm_pkg;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_SPS       = 8;
  localparam int DEF_ERASE_TH  = 64;

  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    DUMP
  } det_state_e;

endpackage

// File: rtl/decision_buffer.sv
// decision_buffer
//   One-entry valid/ready output register for detector decisions.
//   Ports:
//     clk, reset      clock and synchronous active-low reset
//     load            a new decision {bit_in, conf_in, acc_in} is offered
//     ready           consumer takes the held decision when valid & ready
//     clear_ovr       clears the sticky overrun flag
//     bit_out, conf_out, acc_out   held decision, stable until consumed
//     valid           register holds a decision
//     overrun         sticky: a decision arrived while the register was full
module decision_buffer #(
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    bit_in,
  input  logic                    conf_in,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    ready,
  input  logic                    clear_ovr,
  output logic                    bit_out,
  output logic                    conf_out,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    valid,
  output logic                    overrun
);

  logic consume;
  logic accept;
  logic drop;

  // A load is accepted when the slot is empty or is being emptied on the
  // same edge; otherwise the incoming decision is lost.
  assign consume = valid & ready;
  assign accept  = load & (~valid | consume);
  assign drop    = load & valid & ~ready;

  // Data is only rewritten on an accepted load, so it stays stable while the
  // consumer stalls. A drop beats a simultaneous clear of overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid    <= 1'b0;
      bit_out  <= 1'b0;
      conf_out <= 1'b0;
      acc_out  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        valid    <= 1'b1;
        bit_out  <= bit_in;
        conf_out <= conf_in;
        acc_out  <= acc_in;
      end else if (consume) begin
        valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/integrate_dump_detector.sv
// integrate_dump_detector
//   Integrate-and-dump symbol detector after the channel block. Sums SPS
//   samples per symbol, slices the sum into a hard bit and a confidence flag
//   and hands decisions to the decoder over valid/ready.
//   Ports:
//     CLOCK_50        system clock (rising edge)
//     reset           synchronous active-low reset
//     enable          0 flushes the integrator back to IDLE
//     sample_in       signed channel sample, qualified by sample_valid
//     sym_start       with sample_valid: first sample of a symbol
//     bit_out         decided bit (sum >= 0 -> 1)
//     bit_conf        1 when |sum| >= ERASE_TH
//     acc_out         integrator sum behind bit_out
//     bit_valid       output register holds a decision; bit_ready accepts it
//     sync_err        one-cycle pulse on a mid-symbol sym_start
//     overrun         sticky dropped-decision flag, cleared by clear_ovr
module integrate_dump_detector
  import comm_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SPS      = DEF_SPS,
  parameter int ACC_W    = SAMPLE_W + $clog2(SPS),
  parameter int ERASE_TH = DEF_ERASE_TH
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       sym_start,
  output logic                       bit_out,
  output logic                       bit_conf,
  output logic signed [ACC_W-1:0]    acc_out,
  output logic                       bit_valid,
  input  logic                       bit_ready,
  output logic                       sync_err,
  output logic                       overrun,
  input  logic                       clear_ovr
);

  localparam int CNT_W = $clog2(SPS + 1);
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(SPS - 1);
  localparam logic signed [ACC_W-1:0] TH_POS   = ACC_W'(ERASE_TH);
  localparam logic signed [ACC_W-1:0] TH_NEG   = -TH_POS;

  det_state_e              state;
  det_state_e              state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] sample_ext;
  logic                    sync_err_nxt;
  logic                    dump_now;

  logic                    dec_load;
  logic                    dec_bit;
  logic                    dec_conf;
  logic signed [ACC_W-1:0] dec_acc;

  assign sample_ext = {{(ACC_W - SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};

  // Next-state logic. While in DUMP, acc still holds the finished symbol sum.
  // A sample arriving in DUMP opens the next symbol, so symbols run back to
  // back without further sym_start. A sym_start on an empty integrator is a
  // normal first sample, not a resync.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    sync_err_nxt = 1'b0;
    dump_now     = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      acc_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid && sym_start) begin
            acc_nxt   = sample_ext;
            cnt_nxt   = CNT_W'(1);
            state_nxt = INTEGRATE;
          end
        end
        INTEGRATE: begin
          if (sample_valid) begin
            if (sym_start && (cnt != '0)) begin
              acc_nxt      = sample_ext;
              cnt_nxt      = CNT_W'(1);
              sync_err_nxt = 1'b1;
            end else begin
              acc_nxt = acc + sample_ext;
              cnt_nxt = cnt + CNT_W'(1);
              if (cnt == LAST_CNT) begin
                state_nxt = DUMP;
              end
            end
          end
        end
        DUMP: begin
          dump_now  = 1'b1;
          state_nxt = INTEGRATE;
          if (sample_valid) begin
            acc_nxt = sample_ext;
            cnt_nxt = CNT_W'(1);
          end else begin
            acc_nxt = '0;
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          acc_nxt   = '0;
        end
      endcase
    end
  end

  // State, integrator and sync_err registers.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  // Slicer stage: the decision is captured at the end of DUMP and offered to
  // the output register one edge later, which gives the two-edge latency from
  // the last sample of a symbol to bit_valid.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      dec_load <= 1'b0;
      dec_bit  <= 1'b0;
      dec_conf <= 1'b0;
      dec_acc  <= '0;
    end else begin
      dec_load <= dump_now;
      if (dump_now) begin
        dec_bit  <= ~acc[ACC_W-1];
        dec_conf <= (acc >= TH_POS) || (acc <= TH_NEG);
        dec_acc  <= acc;
      end
    end
  end

  decision_buffer #(
    .ACC_W (ACC_W)
  ) u_decision_buffer (
    .clk       (CLOCK_50),
    .reset     (reset),
    .load      (dec_load),
    .bit_in    (dec_bit),
    .conf_in   (dec_conf),
    .acc_in    (dec_acc),
    .ready     (bit_ready),
    .clear_ovr (clear_ovr),
    .bit_out   (bit_out),
    .conf_out  (bit_conf),
    .acc_out   (acc_out),
    .valid     (bit_valid),
    .overrun   (overrun)
  );

endmodule
